// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine.
// Holds the cipher state and the running round key in registers and applies
// ROUNDS_PER_CYCLE unrolled rounds per clock. A valid/ready handshake is used
// on both the plaintext side and the ciphertext side.
module aes128_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int OUTPUT_LAST_KEY  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [127:0] key_out,
    output logic         busy
);

    // Only divisors of ten give a whole number of cycles per block.
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rounds
        $error("aes128_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 255 - int'(x);
        return SBOX[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, w4, w5, w6, w7;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w4 = w0 ^ t;
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] key_reg, key_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic         in_ready_reg;
    logic [127:0] cascade_state, cascade_key;
    logic         last_cycle;

    // Rounds rnd .. rnd+ROUNDS_PER_CYCLE-1 evaluated back to back; round 10 skips MixColumns.
    always_comb begin
        logic [127:0] st;
        logic [127:0] k;
        logic [127:0] sr;
        logic [3:0]   r_idx;
        st = state_reg;
        k  = key_reg;
        sr = '0;
        r_idx = '0;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            r_idx = rnd_reg + 4'(r);
            k  = key_expand(k, rcon(r_idx));
            sr = shift_rows(sub_bytes(st));
            st = ((r_idx == 4'd10) ? sr : mix_columns(sr)) ^ k;
        end
        cascade_state = st;
        cascade_key   = k;
    end

    assign last_cycle = (5'(rnd_reg) + 5'(ROUNDS_PER_CYCLE)) >= 5'd11;

    // Next-state and datapath update selection.
    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        key_next   = key_reg;
        rnd_next   = rnd_reg;
        case (fsm_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    state_next = plaintext ^ key_in;
                    key_next   = key_in;
                    rnd_next   = 4'd1;
                    fsm_next   = RUN;
                end
            end
            RUN: begin
                state_next = cascade_state;
                key_next   = cascade_key;
                if (last_cycle) begin
                    rnd_next = 4'd10;
                    fsm_next = DONE;
                end else begin
                    rnd_next = rnd_reg + 4'(ROUNDS_PER_CYCLE);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // State registers; in_ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg      <= IDLE;
            state_reg    <= '0;
            key_reg      <= '0;
            rnd_reg      <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            fsm_reg      <= fsm_next;
            state_reg    <= state_next;
            key_reg      <= key_next;
            rnd_reg      <= rnd_next;
            in_ready_reg <= (fsm_next == IDLE);
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = (fsm_reg == DONE);
    assign busy       = (fsm_reg != IDLE);
    assign ciphertext = out_valid ? state_reg : '0;

    if (OUTPUT_LAST_KEY != 0) begin : g_key_out
        assign key_out = out_valid ? key_reg : '0;
    end else begin : g_no_key_out
        assign key_out = '0;
    end

endmodule

// File: tb/tb_aes128_round_engine.sv
// Self-checking bench for aes128_round_engine: FIPS-197 vectors, random blocks
// against a byte-array AES reference model, backpressure, back-to-back,
// mid-block reset and ignored input.
module tb_aes128_round_engine;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_KO  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Main engine, ROUNDS_PER_CYCLE = 1
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] plaintext, key_in, ciphertext, key_out;

    aes128_round_engine #(.ROUNDS_PER_CYCLE(1), .OUTPUT_LAST_KEY(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key_in(key_in), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .key_out(key_out), .busy(busy)
    );

    // Unrolled engines: index 0 -> 2 rounds, 1 -> 5 rounds, 2 -> 10 rounds (no key_out)
    logic [2:0]   p_in_valid, p_in_ready, p_out_valid, p_busy;
    logic         p_out_ready;
    logic [127:0] p_pt, p_key;
    logic [127:0] p_ct [3];
    logic [127:0] p_ko [3];

    aes128_round_engine #(.ROUNDS_PER_CYCLE(2), .OUTPUT_LAST_KEY(1)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid[0]), .in_ready(p_in_ready[0]),
        .plaintext(p_pt), .key_in(p_key), .out_valid(p_out_valid[0]),
        .out_ready(p_out_ready), .ciphertext(p_ct[0]), .key_out(p_ko[0]), .busy(p_busy[0])
    );
    aes128_round_engine #(.ROUNDS_PER_CYCLE(5), .OUTPUT_LAST_KEY(1)) u_r5 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid[1]), .in_ready(p_in_ready[1]),
        .plaintext(p_pt), .key_in(p_key), .out_valid(p_out_valid[1]),
        .out_ready(p_out_ready), .ciphertext(p_ct[1]), .key_out(p_ko[1]), .busy(p_busy[1])
    );
    aes128_round_engine #(.ROUNDS_PER_CYCLE(10), .OUTPUT_LAST_KEY(0)) u_r10 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid[2]), .in_ready(p_in_ready[2]),
        .plaintext(p_pt), .key_in(p_key), .out_valid(p_out_valid[2]),
        .out_ready(p_out_ready), .ciphertext(p_ct[2]), .key_out(p_ko[2]), .busy(p_busy[2])
    );

    // ---------------- reference model ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] last_key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, x, a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = key[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rc;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        ct = '0;
        last_key = '0;
        for (int i = 0; i < 16; i++) begin
            ct[127-8*i -: 8]       = s[i];
            last_key[127-8*i -: 8] = w[160+i];
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Present one block to the main engine and wait for its result; lat = -1 on timeout.
    task automatic run1(input logic [127:0] pt, input logic [127:0] k,
                        output logic [127:0] ct, output logic [127:0] ko, output int lat);
        int e0;
        lat = -1;
        @(negedge clk);
        plaintext = pt; key_in = k; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        e0 = cyc;
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                lat = cyc - e0;
                break;
            end
            @(negedge clk);
        end
        ct = ciphertext;
        ko = key_out;
    endtask

    task automatic runp(input int n, input logic [127:0] pt, input logic [127:0] k,
                        output logic [127:0] ct, output logic [127:0] ko, output int lat);
        int e0;
        lat = -1;
        @(negedge clk);
        p_pt = pt; p_key = k; p_in_valid[n] = 1'b1;
        for (int i = 0; i < 40 && !p_in_ready[n]; i++) @(negedge clk);
        @(negedge clk);
        e0 = cyc;
        p_in_valid[n] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (p_out_valid[n]) begin
                lat = cyc - e0;
                break;
            end
            @(negedge clk);
        end
        ct = p_ct[n];
        ko = p_ko[n];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ciphertext !== '0) begin failures++; $display("FAIL reset_ciphertext got=%h exp=0", ciphertext); end
        checks++; if (key_out !== '0) begin failures++; $display("FAIL reset_key_out got=%h exp=0", key_out); end
        checks++; if (p_in_ready !== 3'b000 || p_out_valid !== 3'b000) begin
            failures++; $display("FAIL reset_unrolled got_ready=%b got_valid=%b exp=000", p_in_ready, p_out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (p_in_ready !== 3'b111) begin failures++; $display("FAIL reset_release_unrolled got=%b exp=111", p_in_ready); end
        $display("reset: released, in_ready=%b", in_ready);
    endtask

    task automatic test_fips_b();
        logic [127:0] ct, ko;
        int lat;
        run1(B_PT, B_KEY, ct, ko, lat);
        checks++; if (ct !== B_CT) begin failures++; $display("FAIL fips_b_ct got=%h exp=%h", ct, B_CT); end
        checks++; if (ko !== B_KO) begin failures++; $display("FAIL fips_b_key_out got=%h exp=%h", ko, B_KO); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL fips_b_latency got=%0d exp=10", lat); end
        $display("fips_b: ct=%h key_out=%h latency=%0d", ct, ko, lat);
    endtask

    task automatic test_c1_unrolled();
        logic [127:0] ct, ko, exp_ct, exp_ko;
        int lat;
        int exp_lat [3] = '{5, 2, 1};
        aes_ref(C_PT, C_KEY, exp_ct, exp_ko);
        for (int n = 0; n < 3; n++) begin
            runp(n, C_PT, C_KEY, ct, ko, lat);
            checks++; if (ct !== C_CT) begin failures++; $display("FAIL c1_ct[%0d] got=%h exp=%h", n, ct, C_CT); end
            checks++; if (lat !== exp_lat[n]) begin failures++; $display("FAIL c1_latency[%0d] got=%0d exp=%0d", n, lat, exp_lat[n]); end
            checks++; if (ko !== ((n == 2) ? 128'h0 : exp_ko)) begin
                failures++; $display("FAIL c1_key_out[%0d] got=%h exp=%h", n, ko, (n == 2) ? 128'h0 : exp_ko);
            end
            $display("c1[%0d]: ct=%h latency=%0d", n, ct, lat);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, k, ct, ko, exp_ct, exp_ko;
        int lat;
        for (int i = 0; i < 6; i++) begin
            pt = rand128(); k = rand128();
            aes_ref(pt, k, exp_ct, exp_ko);
            run1(pt, k, ct, ko, lat);
            checks++; if (ct !== exp_ct) begin failures++; $display("FAIL random_ct[%0d] got=%h exp=%h", i, ct, exp_ct); end
            checks++; if (ko !== exp_ko) begin failures++; $display("FAIL random_key_out[%0d] got=%h exp=%h", i, ko, exp_ko); end
            checks++; if (lat !== 10) begin failures++; $display("FAIL random_latency[%0d] got=%0d exp=10", i, lat); end
            $display("random[%0d]: pt=%h key=%h ct=%h", i, pt, k, ct);
        end
        for (int n = 0; n < 3; n++) begin
            pt = rand128(); k = rand128();
            aes_ref(pt, k, exp_ct, exp_ko);
            runp(n, pt, k, ct, ko, lat);
            checks++; if (ct !== exp_ct) begin failures++; $display("FAIL random_unrolled_ct[%0d] got=%h exp=%h", n, ct, exp_ct); end
            $display("random_unrolled[%0d]: pt=%h key=%h ct=%h", n, pt, k, ct);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt2, k2, exp_ct, exp_ko;
        int e0, lat;
        out_ready = 1'b0;
        @(negedge clk);
        plaintext = B_PT; key_in = B_KEY; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        e0 = cyc;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            plaintext = rand128(); key_in = rand128();
            if (out_valid) begin lat = cyc - e0; break; end
            @(negedge clk);
        end
        checks++; if (lat !== 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", lat); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (ciphertext !== B_CT || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d] got ct=%h ov=%b ir=%b exp ct=%h ov=1 ir=0",
                                     i, ciphertext, out_valid, in_ready, B_CT);
            end
            plaintext = rand128(); key_in = rand128();
            if (i < 7) @(negedge clk);
        end
        pt2 = rand128(); k2 = rand128();
        plaintext = pt2; key_in = k2; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_handoff got ov=%b ir=%b busy=%b exp ov=0 ir=1 busy=0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_next_accept got busy=%b ir=%b exp busy=1 ir=0", busy, in_ready);
        end
        e0 = cyc;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin lat = cyc - e0; break; end
            @(negedge clk);
        end
        aes_ref(pt2, k2, exp_ct, exp_ko);
        checks++; if (ciphertext !== exp_ct || lat !== 10) begin
            failures++; $display("FAIL bp_next_block got ct=%h lat=%0d exp ct=%h lat=10", ciphertext, lat, exp_ct);
        end
        $display("backpressure: held ct=%h, next ct=%h latency=%0d", B_CT, ciphertext, lat);
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct1, ct2;
        int ea, eb, lat;
        out_ready = 1'b1;
        @(negedge clk);
        plaintext = B_PT; key_in = B_KEY; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        ea = cyc;
        plaintext = C_PT; key_in = C_KEY;
        ct1 = '0; eb = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin ct1 = ciphertext; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && !out_valid) begin eb = cyc; break; end
        end
        in_valid = 1'b0;
        ct2 = '0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin ct2 = ciphertext; lat = cyc - eb; break; end
            @(negedge clk);
        end
        checks++; if (ct1 !== B_CT) begin failures++; $display("FAIL b2b_first got=%h exp=%h", ct1, B_CT); end
        checks++; if (ct2 !== C_CT) begin failures++; $display("FAIL b2b_second got=%h exp=%h", ct2, C_CT); end
        checks++; if (eb - ea !== 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12", eb - ea); end
        $display("back_to_back: ct1=%h ct2=%h spacing=%0d", ct1, ct2, eb - ea);
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct, ko, exp_ct, exp_ko;
        int lat;
        bit pulse;
        @(negedge clk);
        plaintext = C_PT; key_in = C_KEY; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
                     ciphertext !== '0 || key_out !== '0) begin
            failures++; $display("FAIL midreset_outputs got ov=%b busy=%b ir=%b ct=%h ko=%h exp all 0",
                                 out_valid, busy, in_ready, ciphertext, key_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        pulse = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) pulse = 1'b1;
            @(negedge clk);
        end
        checks++; if (pulse) begin failures++; $display("FAIL midreset_no_output got=1 exp=0"); end
        aes_ref(C_PT, C_KEY, exp_ct, exp_ko);
        run1(C_PT, C_KEY, ct, ko, lat);
        checks++; if (ct !== C_CT || ko !== exp_ko || lat !== 10) begin
            failures++; $display("FAIL midreset_rerun got ct=%h ko=%h lat=%0d exp ct=%h ko=%h lat=10",
                                 ct, ko, lat, C_CT, exp_ko);
        end
        $display("reset_mid: rerun ct=%h latency=%0d", ct, lat);
    endtask

    task automatic test_ignored_input();
        logic [127:0] pt, k, exp_ct, exp_ko;
        int e0, lat;
        pt = rand128(); k = rand128();
        aes_ref(pt, k, exp_ct, exp_ko);
        @(negedge clk);
        plaintext = pt; key_in = k; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        e0 = cyc;
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = (i % 3 == 1);
            plaintext = rand128(); key_in = rand128();
            @(negedge clk);
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                failures++; $display("FAIL ignored_run[%0d] got busy=%b ir=%b ov=%b exp busy=1 ir=0 ov=0",
                                     i, busy, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin lat = cyc - e0; break; end
            @(negedge clk);
        end
        checks++; if (ciphertext !== exp_ct || lat !== 10) begin
            failures++; $display("FAIL ignored_result got ct=%h lat=%0d exp ct=%h lat=10", ciphertext, lat, exp_ct);
        end
        $display("ignored_input: ct=%h latency=%0d", ciphertext, lat);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        plaintext = '0; key_in = '0;
        p_in_valid = 3'b000; p_out_ready = 1'b1; p_pt = '0; p_key = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        test_reset();
        test_fips_b();
        test_c1_unrolled();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_ignored_input();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes128_round_engine.md
# aes128_round_engine

Iterative AES-128 encryption core built around the team's existing combinational round primitives: key generation, SubBytes, ShiftRows and MixColumns, where MixColumns is bypassed on the last round. It registers the cipher state and the running round key. It applies `ROUNDS_PER_CYCLE` unrolled rounds per clock and sequences the ten rounds, including the round constants and the final round without MixColumns. A valid/ready handshake on each side lets it sit between a block-feeding source and a ciphertext sink.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds evaluated per clock; legal values 1, 2, 5, 10; any other value is an elaboration error.
- `OUTPUT_LAST_KEY`, default 1: when 1, `key_out` carries round key 10; when 0, `key_out` is tied to 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  plaintext/key presented.
- `in_ready`  out  1  engine can accept a block.
- `plaintext`  in  128  block, byte 0 in bits [127:120].
- `key_in`  in  128  cipher key, same byte order.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  sink accepts ciphertext.
- `ciphertext`  out  128  result, held stable while `out_valid` is high and `out_ready` is low.
- `key_out`  out  128  round-10 key of the current result; valid only with `out_valid`.
- `busy`  out  1  high in RUN and DONE.

## Operation
- State machine: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: state_reg <= plaintext ^ key_in, key_reg <= key_in, rnd <= 1, go to RUN.
- **RUN:**
  - Each cycle applies rounds rnd .. rnd+ROUNDS_PER_CYCLE-1 in cascade.
  - Each round computes key_i = KeyExpand(key_{i-1}, Rcon[i]), then state = MixColumns(ShiftRows(SubBytes(state))) ^ key_i.
  - MixColumns is bypassed for round 10.
  - key_reg and state_reg take the values at the end of the last round in the cycle; rnd advances by ROUNDS_PER_CYCLE.
  - When the cycle's last round is 10, go to DONE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, in the top byte of the word XOR.
- rnd is a 4-bit counter, range 1..10; it never wraps past 10.
- **DONE:**
  - `out_valid`=1, ciphertext=state_reg, key_out=key_reg (when OUTPUT_LAST_KEY=1).
  - On `out_ready` go to IDLE.
  - `in_ready` stays 0 in DONE; there is no back-to-back overlap.
- `plaintext`/`key_in` are sampled only on the accept edge; later changes are ignored.
- `in_valid` asserted in RUN or DONE is not accepted; the source must hold it until `in_ready`.
- All arithmetic is GF(2^8) with reduction polynomial 0x11b; there is no carry between bytes.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - FSM to IDLE, state_reg=0, key_reg=0, rnd=0.
  - Outputs: `in_ready`=0 while `rst_n` is low, then 1 from the first edge with `rst_n` high; `out_valid`=0, `busy`=0, `ciphertext`=0, `key_out`=0.
- Reset mid-RUN or mid-DONE aborts the block with no output. A pending `out_valid` drops at that edge.
- Latency:
  - Accept at edge E0; `out_valid` rises after edge E0+10/ROUNDS_PER_CYCLE.
  - This gives 10, 5, 2 and 1 cycles for the legal parameter values.
- Throughput: one block per (10/ROUNDS_PER_CYCLE + 2) cycles when `out_ready` is tied high. The extra cycles are the IDLE accept and the DONE handoff.
- `out_valid` && !`out_ready`: the engine stalls indefinitely in DONE with outputs held bit-stable.
- `in_ready` and `out_valid` are never high in the same cycle.
- All outputs are registered or decoded from FSM state only; there are no combinational in-to-out paths.

## Test plan
- **FIPS-197 App. B vector, ROUNDS_PER_CYCLE=1.**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, `out_ready`=1.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32 and key_out d014f9a8c9ee2589e13f0cc8b6630ca6. `out_valid` rises exactly 10 cycles after the accept edge.
- **FIPS-197 App. C.1 vector, for each of ROUNDS_PER_CYCLE = 2, 5, 10.**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with latency 5, 2 and 1 cycles respectively.
- **Backpressure.**
  - Stimulus: App. B vector with `out_ready`=0 for 7 cycles after `out_valid`; toggle `plaintext`/`key_in` randomly with `in_valid`=1 throughout.
  - Required: ciphertext stays 3925841d… and `in_ready` stays 0. The handoff completes on the first `out_ready`=1 edge, and the next block is accepted one cycle later.
- **Back-to-back.**
  - Stimulus: App. B vector, then the C.1 vector queued with `in_valid` held, `out_ready`=1.
  - Required: both results are correct and in order. Accept edges are 12 cycles apart at ROUNDS_PER_CYCLE=1.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n`=0 for 1 cycle 4 cycles after accept.
  - Required: no `out_valid` pulse; all outputs are 0 after the edge and `in_ready`=1 on the following cycle. A fresh C.1 run then completes correctly.
- **Ignored input.**
  - Stimulus: `in_valid` pulsed during RUN only.
  - Required: no accept, FSM stays in RUN, and the original result is unchanged.
